// File: rtl/uart_frame_parser.sv
// uart_frame_parser: turns the UART byte stream into ACU command frames
// (9 bytes) and plank configuration frames (22 bytes). It checks header,
// type, XOR checksum, footer and inter-byte timeout, and raises an ACK/NAK
// strobe for every frame outcome. Plank payloads are double-buffered, so a
// frame in progress never disturbs readers of the active bank.
module uart_frame_parser #(
  parameter int         TIMEOUT_CYC = 17360,
  parameter logic [7:0] HDR         = 8'hAA,
  parameter logic [7:0] FTR         = 8'h55
) (
  input  logic       i_clk_100,
  input  logic       i_rst,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic [3:0] o_enable,
  output logic [5:0] o_ATT1,
  output logic [5:0] o_ATT2,
  output logic [5:0] o_ATT3,
  output logic [5:0] o_ATT4,
  output logic       o_BITE_CNTRL,
  output logic       o_SUB_ARRAY,
  output logic       o_acu_update,
  output logic       o_plank_valid,
  output logic [2:0] o_plank_id,
  output logic [3:0] o_plank_flags,
  input  logic [4:0] i_plank_rd_addr,
  output logic [7:0] o_plank_rd_data,
  output logic       o_ack_valid,
  output logic [7:0] o_ack_byte,
  output logic       o_frame_err,
  output logic [1:0] o_err_code
);

  localparam int            TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TYPE   = 3'd1,
    S_BODY   = 3'd2,
    S_CSUM   = 3'd3,
    S_FOOTER = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_xor;
  logic [3:0]      r_flags;
  logic            r_is_plank;
  logic [4:0]      r_idx;
  logic [5:0]      r_stg_att [0:3];
  logic            r_stg_sub;
  logic            r_stg_bite;
  logic [2:0]      r_stg_id;
  logic            r_active;
  logic [7:0]      r_mem [0:1][0:16];

  logic            w_expire;
  logic            w_type_ok;
  logic [4:0]      w_body_last;
  logic            w_good;
  logic            w_err;
  logic [1:0]      w_err_code;

  // Expiry only fires on a byte-less cycle: a byte arriving on the expiry
  // cycle is processed normally and restarts the count.
  assign w_expire    = (r_state != S_IDLE) && !i_rx_dv && (r_to_cnt == TO_LAST);
  assign w_type_ok   = (i_rx_byte[3:0] == 4'h1) || (i_rx_byte[3:0] == 4'h2);
  assign w_body_last = r_is_plank ? 5'd17 : 5'd4;

  // State register.
  always_ff @(posedge i_clk_100) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: timeout aborts, otherwise advance on each received byte.
  always_comb begin
    w_next = r_state;
    if (w_expire) begin
      w_next = S_IDLE;
    end else if (i_rx_dv) begin
      case (r_state)
        S_IDLE:   if (i_rx_byte == HDR) w_next = S_TYPE;   else w_next = S_IDLE;
        S_TYPE:   if (w_type_ok)        w_next = S_BODY;   else w_next = S_IDLE;
        S_BODY:   if (r_idx == w_body_last) w_next = S_CSUM; else w_next = S_BODY;
        S_CSUM:   if (i_rx_byte == r_xor) w_next = S_FOOTER; else w_next = S_IDLE;
        S_FOOTER: w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end else begin
      w_next = r_state;
    end
  end

  // Outcome decode: which frame completes or is rejected on this cycle.
  always_comb begin
    w_good     = 1'b0;
    w_err      = 1'b0;
    w_err_code = 2'd0;
    if (w_expire) begin
      w_err      = 1'b1;
      w_err_code = 2'd3;
    end else if (i_rx_dv) begin
      case (r_state)
        S_TYPE: begin
          if (!w_type_ok) begin w_err = 1'b1; w_err_code = 2'd0; end
          else            begin w_err = 1'b0; end
        end
        S_CSUM: begin
          if (i_rx_byte != r_xor) begin w_err = 1'b1; w_err_code = 2'd1; end
          else                    begin w_err = 1'b0; end
        end
        S_FOOTER: begin
          if (i_rx_byte == FTR) begin w_good = 1'b1; end
          else                  begin w_err = 1'b1; w_err_code = 2'd2; end
        end
        default: begin
          w_good = 1'b0;
        end
      endcase
    end else begin
      w_good = 1'b0;
    end
  end

  // Frame datapath: timeout counter, checksum, staging and published outputs.
  always_ff @(posedge i_clk_100) begin
    if (i_rst) begin
      r_to_cnt      <= {TO_W{1'b0}};
      r_xor         <= 8'h00;
      r_flags       <= 4'h0;
      r_is_plank    <= 1'b0;
      r_idx         <= 5'd0;
      for (int i = 0; i < 4; i++) r_stg_att[i] <= 6'd0;
      r_stg_sub     <= 1'b0;
      r_stg_bite    <= 1'b0;
      r_stg_id      <= 3'd0;
      r_active      <= 1'b0;
      o_enable      <= 4'h0;
      o_ATT1        <= 6'd0;
      o_ATT2        <= 6'd0;
      o_ATT3        <= 6'd0;
      o_ATT4        <= 6'd0;
      o_BITE_CNTRL  <= 1'b0;
      o_SUB_ARRAY   <= 1'b0;
      o_acu_update  <= 1'b0;
      o_plank_valid <= 1'b0;
      o_plank_id    <= 3'd0;
      o_plank_flags <= 4'h0;
      o_ack_valid   <= 1'b0;
      o_ack_byte    <= 8'h00;
      o_frame_err   <= 1'b0;
      o_err_code    <= 2'd0;
    end else begin
      o_acu_update  <= 1'b0;
      o_plank_valid <= 1'b0;
      o_ack_valid   <= 1'b0;
      o_frame_err   <= 1'b0;

      if (i_rx_dv || (r_state == S_IDLE) || w_expire) r_to_cnt <= {TO_W{1'b0}};
      else                                            r_to_cnt <= r_to_cnt + TO_W'(1);

      if (i_rx_dv) begin
        case (r_state)
          S_IDLE: begin
            if (i_rx_byte == HDR) r_xor <= HDR;
          end
          S_TYPE: begin
            r_xor      <= r_xor ^ i_rx_byte;
            r_flags    <= i_rx_byte[7:4];
            r_is_plank <= (i_rx_byte[3:0] == 4'h2);
            r_idx      <= 5'd0;
          end
          S_BODY: begin
            r_xor <= r_xor ^ i_rx_byte;
            r_idx <= r_idx + 5'd1;
            if (r_is_plank) begin
              if (r_idx == 5'd17) r_stg_id <= i_rx_byte[2:0];
            end else if (r_idx < 5'd4) begin
              r_stg_att[r_idx[1:0]] <= i_rx_byte[5:0];
            end else begin
              r_stg_sub  <= i_rx_byte[1];
              r_stg_bite <= i_rx_byte[0];
            end
          end
          default: begin
            r_xor <= r_xor;
          end
        endcase
      end

      if (w_good) begin
        o_ack_valid <= 1'b1;
        o_ack_byte  <= 8'hEE;
        if (r_is_plank) begin
          r_active      <= ~r_active;
          o_plank_id    <= r_stg_id;
          o_plank_flags <= r_flags;
          o_plank_valid <= 1'b1;
        end else begin
          o_enable     <= r_flags;
          o_ATT1       <= r_stg_att[0];
          o_ATT2       <= r_stg_att[1];
          o_ATT3       <= r_stg_att[2];
          o_ATT4       <= r_stg_att[3];
          o_SUB_ARRAY  <= r_stg_sub;
          o_BITE_CNTRL <= r_stg_bite;
          o_acu_update <= 1'b1;
        end
      end

      if (w_err) begin
        o_ack_valid <= 1'b1;
        o_ack_byte  <= 8'hFF;
        o_frame_err <= 1'b1;
        o_err_code  <= w_err_code;
      end
    end
  end

  // Payload RAM write: plank body bytes go to the bank readers are not using.
  always_ff @(posedge i_clk_100) begin
    if (i_rx_dv && (r_state == S_BODY) && r_is_plank && (r_idx <= 5'd16)) begin
      r_mem[~r_active][r_idx] <= i_rx_byte;
    end
  end

  // Payload read port: registered, out-of-range addresses read as zero.
  always_ff @(posedge i_clk_100) begin
    if (i_rst)                          o_plank_rd_data <= 8'h00;
    else if (i_plank_rd_addr <= 5'd16)  o_plank_rd_data <= r_mem[r_active][i_plank_rd_addr];
    else                                o_plank_rd_data <= 8'h00;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed vector table, hand-written corner
// sequences, then random byte streams checked against a frame-level model.
module tb_uart_frame_parser;

  localparam int         TO  = 64;
  localparam logic [7:0] HDR = 8'hAA;
  localparam logic [7:0] FTR = 8'h55;

  logic       clk = 1'b0;
  logic       i_rst, i_rx_dv;
  logic [7:0] i_rx_byte;
  logic [3:0] o_enable;
  logic [5:0] o_ATT1, o_ATT2, o_ATT3, o_ATT4;
  logic       o_BITE_CNTRL, o_SUB_ARRAY, o_acu_update, o_plank_valid;
  logic [2:0] o_plank_id;
  logic [3:0] o_plank_flags;
  logic [4:0] i_plank_rd_addr;
  logic [7:0] o_plank_rd_data;
  logic       o_ack_valid;
  logic [7:0] o_ack_byte;
  logic       o_frame_err;
  logic [1:0] o_err_code;

  uart_frame_parser #(.TIMEOUT_CYC(TO), .HDR(HDR), .FTR(FTR)) dut (
    .i_clk_100(clk), .i_rst(i_rst), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
    .o_enable(o_enable), .o_ATT1(o_ATT1), .o_ATT2(o_ATT2), .o_ATT3(o_ATT3),
    .o_ATT4(o_ATT4), .o_BITE_CNTRL(o_BITE_CNTRL), .o_SUB_ARRAY(o_SUB_ARRAY),
    .o_acu_update(o_acu_update), .o_plank_valid(o_plank_valid),
    .o_plank_id(o_plank_id), .o_plank_flags(o_plank_flags),
    .i_plank_rd_addr(i_plank_rd_addr), .o_plank_rd_data(o_plank_rd_data),
    .o_ack_valid(o_ack_valid), .o_ack_byte(o_ack_byte),
    .o_frame_err(o_frame_err), .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ackv;
    logic [7:0] ab;
    logic       err;
    logic [1:0] code;
    logic       au;
    logic       pv;
  } ev_t;

  typedef struct packed {
    logic [0:8][7:0] by;
    int              lat;   // index of the byte whose outcome is reported
    logic            err;
    logic [1:0]      code;
    logic [29:0]     acu;   // {enable, att1..4, sub, bite} after the frame
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  ev_t  got_q[$];
  int   got_cyc[$];
  ev_t  exp_q[$];
  logic [7:0] bq[$];
  int   dq[$];

  // model state
  logic [29:0] m_acu;
  logic [2:0]  m_pid;
  logic [3:0]  m_pflags;
  logic [7:0]  m_pay [0:16];
  bit          m_pay_known;

  localparam logic [29:0] ACU_A = {4'hF, 6'h33, 6'h2A, 6'h38, 6'h24, 1'b1, 1'b1};
  localparam logic [29:0] ACU_B = {4'h5, 6'h01, 6'h02, 6'h3F, 6'h10, 1'b1, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  // collect every pulse with the cycle it was seen on
  always @(negedge clk) begin
    if (o_ack_valid || o_frame_err || o_acu_update || o_plank_valid) begin
      got_q.push_back('{o_ack_valid, o_ack_byte, o_frame_err,
                        (o_frame_err ? o_err_code : 2'd0), o_acu_update, o_plank_valid});
      got_cyc.push_back(cyc);
    end
  end

  function automatic ev_t ev_ok(input bit pl);
    return '{1'b1, 8'hEE, 1'b0, 2'd0, !pl, pl};
  endfunction

  function automatic ev_t ev_bad(input logic [1:0] c);
    return '{1'b1, 8'hFF, 1'b1, c, 1'b0, 1'b0};
  endfunction

  function automatic logic [29:0] acu_now();
    return {o_enable, o_ATT1, o_ATT2, o_ATT3, o_ATT4, o_SUB_ARRAY, o_BITE_CNTRL};
  endfunction

  function automatic logic [63:0] all_out();
    return {5'd0, acu_now(), o_acu_update, o_plank_valid, o_plank_id, o_plank_flags,
            o_plank_rd_data, o_ack_valid, o_ack_byte, o_frame_err, o_err_code};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // d = distance in cycles from the previous byte strobe
  task automatic send(input logic [7:0] b, input int d);
    repeat (d - 1) begin @(posedge clk); #1; end
    i_rx_dv = 1'b1; i_rx_byte = b; last_cyc = cyc;
    @(posedge clk); #1;
    i_rx_dv = 1'b0;
  endtask

  task automatic expect_ev(input string nm, input ev_t e, input int ecyc);
    check({nm, " events"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      check({nm, " outcome"}, got_q[0], e);
      check({nm, " latency"}, got_cyc[0], ecyc);
    end
    got_q.delete(); got_cyc.delete();
  endtask

  task automatic rd_chk(input int a, input logic [7:0] exp);
    i_plank_rd_addr = 5'(a);
    @(posedge clk); #1;
    check($sformatf("rd a%0d", a), o_plank_rd_data, exp);
  endtask

  task automatic send_plank(input logic [7:0] fill, input logic [7:0] idb, input logic [7:0] cs);
    send(HDR, 1); send(8'hE2, 1);
    for (int i = 0; i < 17; i++) send(fill, 1);
    send(idb, 1); send(cs, 1); send(FTR, 1);
  endtask

  // random frame generator: good, bad type/checksum/footer, timeout gap, junk
  task automatic gen_frame();
    int kind, len, ti;
    logic [7:0] f[$];
    logic [7:0] ty, x;
    kind = $urandom_range(0, 6);
    if (kind == 6) begin
      repeat ($urandom_range(1, 3)) f.push_back(8'($urandom));
    end else begin
      ty[7:4] = 4'($urandom);
      ty[3:0] = ($urandom_range(0, 1) != 0) ? 4'h2 : 4'h1;
      if (kind == 2) begin
        ti = $urandom_range(3, 16);
        ty[3:0] = (ti == 16) ? 4'h0 : 4'(ti);
      end
      f.push_back(HDR); f.push_back(ty);
      if (kind != 2) begin
        len = (ty[3:0] == 4'h2) ? 18 : 5;
        for (int i = 0; i < len; i++) f.push_back(8'($urandom));
        x = 8'h00;
        foreach (f[i]) x ^= f[i];
        if (kind == 3) x ^= 8'($urandom_range(1, 255));
        f.push_back(x);
        f.push_back((kind == 4) ? (FTR ^ 8'($urandom_range(1, 255))) : FTR);
      end
    end
    ti = (kind == 5) ? int'($urandom_range(1, f.size() - 1)) : -1;
    foreach (f[i]) begin
      bq.push_back(f[i]);
      if (i == ti)                        dq.push_back(TO + 1 + int'($urandom_range(0, 8)));
      else if ($urandom_range(0, 29) == 0) dq.push_back(TO);
      else                                 dq.push_back(int'($urandom_range(1, 3)));
    end
  endtask

  // Frame-level reference: locate headers, slice frames by offset, XOR-reduce
  // the slice for the checksum, treat any gap longer than TO inside a frame
  // (or the stream ending mid-frame) as a timeout.
  task automatic model_run();
    int n, k, h, j, len;
    logic [7:0] x;
    bit done;
    n = bq.size(); k = 0;
    while (k < n) begin
      if (bq[k] != HDR) begin k++; continue; end
      h = k; j = h + 1; len = 0; done = 0;
      while (!done) begin
        if (j >= n || dq[j] > TO) begin
          exp_q.push_back(ev_bad(2'd3)); k = j; done = 1;
        end else if (j == h + 1) begin
          if (bq[j][3:0] == 4'h1)      begin len = 5;  j++; end
          else if (bq[j][3:0] == 4'h2) begin len = 18; j++; end
          else begin exp_q.push_back(ev_bad(2'd0)); k = j + 1; done = 1; end
        end else if (j < h + 2 + len) begin
          j++;
        end else if (j == h + 2 + len) begin
          x = 8'h00;
          for (int p = h; p < j; p++) x ^= bq[p];
          if (x != bq[j]) begin exp_q.push_back(ev_bad(2'd1)); k = j + 1; done = 1; end
          else j++;
        end else begin
          if (bq[j] != FTR) begin
            exp_q.push_back(ev_bad(2'd2));
          end else if (len == 5) begin
            exp_q.push_back(ev_ok(1'b0));
            m_acu = {bq[h+1][7:4], bq[h+2][5:0], bq[h+3][5:0], bq[h+4][5:0],
                     bq[h+5][5:0], bq[h+6][1], bq[h+6][0]};
          end else begin
            exp_q.push_back(ev_ok(1'b1));
            for (int p = 0; p < 17; p++) m_pay[p] = bq[h + 2 + p];
            m_pid = bq[h+19][2:0]; m_pflags = bq[h+1][7:4]; m_pay_known = 1;
          end
          k = j + 1; done = 1;
        end
      end
    end
  endtask

  vec_t tbl [0:5];
  int   lc;

  initial begin
    tbl[0] = '{by: {8'hAA,8'hF1,8'h33,8'h2A,8'h38,8'h24,8'h03,8'h5D,8'h55}, lat: 8, err: 1'b0, code: 2'd0, acu: ACU_A};
    tbl[1] = '{by: {8'hAA,8'hF1,8'h33,8'h2A,8'h38,8'h24,8'h03,8'h5C,8'h55}, lat: 7, err: 1'b1, code: 2'd1, acu: ACU_A};
    tbl[2] = '{by: {8'hAA,8'hF1,8'h33,8'h2A,8'h38,8'h24,8'h03,8'h5D,8'h54}, lat: 8, err: 1'b1, code: 2'd2, acu: ACU_A};
    tbl[3] = '{by: {8'hAA,8'h13,8'h33,8'h2A,8'h38,8'h24,8'h03,8'h5D,8'h55}, lat: 1, err: 1'b1, code: 2'd0, acu: ACU_A};
    tbl[4] = '{by: {8'hAA,8'h51,8'h01,8'h02,8'h3F,8'h10,8'h02,8'hD5,8'h55}, lat: 8, err: 1'b0, code: 2'd0, acu: ACU_B};
    tbl[5] = '{by: {8'hAA,8'hF1,8'h33,8'h2A,8'h38,8'h24,8'h03,8'h00,8'h55}, lat: 7, err: 1'b1, code: 2'd1, acu: ACU_B};

    i_rst = 1'b1; i_rx_dv = 1'b0; i_rx_byte = 8'h00; i_plank_rd_addr = 5'd0;
    idle(3);
    check("reset outputs", all_out(), 64'd0);
    i_rst = 1'b0;
    idle(2);
    check("no pulses after reset", got_q.size(), 0);

    // directed vector table
    for (int r = 0; r < 6; r++) begin
      lc = 0;
      for (int i = 0; i < 9; i++) begin
        send(tbl[r].by[i], 1);
        if (i == tbl[r].lat) lc = last_cyc;
      end
      idle(3);
      expect_ev($sformatf("vec%0d", r), tbl[r].err ? ev_bad(tbl[r].code) : ev_ok(1'b0), lc + 1);
      check($sformatf("vec%0d acu", r), acu_now(), tbl[r].acu);
    end

    // junk ahead of a good frame, then back-to-back frames with no gap
    send(8'h00, 1); send(8'hFF, 1);
    for (int i = 0; i < 9; i++) send(tbl[0].by[i], 1);
    lc = last_cyc;
    idle(3);
    expect_ev("junk+frame", ev_ok(1'b0), lc + 1);
    check("junk+frame acu", acu_now(), ACU_A);
    for (int i = 0; i < 9; i++) send(tbl[4].by[i], 1);
    for (int i = 0; i < 9; i++) send(tbl[0].by[i], 1);
    idle(3);
    check("b2b events", got_q.size(), 2);
    check("b2b gap", (got_q.size() == 2) ? (got_cyc[1] - got_cyc[0]) : 0, 9);
    got_q.delete(); got_cyc.delete();
    check("b2b acu", acu_now(), ACU_A);

    // plank frames, both banks
    send_plank(8'h32, 8'h00, 8'h7A);
    lc = last_cyc;
    idle(3);
    expect_ev("plank0", ev_ok(1'b1), lc + 1);
    check("plank0 id/flags", {o_plank_id, o_plank_flags}, {3'd0, 4'hE});
    for (int a = 0; a < 32; a++) rd_chk(a, (a <= 16) ? 8'h32 : 8'h00);
    send_plank(8'h32, 8'h05, 8'h7F);
    lc = last_cyc;
    idle(3);
    expect_ev("plank5", ev_ok(1'b1), lc + 1);
    check("plank5 id/flags", {o_plank_id, o_plank_flags}, {3'd5, 4'hE});
    for (int a = 0; a < 18; a++) rd_chk(a, (a <= 16) ? 8'h32 : 8'h00);
    check("plank acu untouched", acu_now(), ACU_A);

    // timeout: stall, then a byte landing exactly on the expiry cycle
    send(HDR, 1); send(8'hF1, 1); send(8'h33, 1);
    lc = last_cyc;
    idle(TO + 4);
    expect_ev("timeout", ev_bad(2'd3), lc + TO + 1);
    for (int i = 0; i < 9; i++) send(tbl[4].by[i], (i == 4) ? TO : 1);
    lc = last_cyc;
    idle(3);
    expect_ev("expiry edge", ev_ok(1'b0), lc + 1);
    check("expiry edge acu", acu_now(), ACU_B);
    for (int i = 0; i < 9; i++) send(tbl[0].by[i], 1);
    lc = last_cyc;
    idle(3);
    expect_ev("after timeout", ev_ok(1'b0), lc + 1);

    // reset in the middle of a plank frame
    send(HDR, 1); send(8'hE2, 1);
    for (int i = 0; i < 8; i++) send(8'h32, 1);
    i_rst = 1'b1;
    idle(1);
    check("midframe reset outputs", all_out(), 64'd0);
    idle(1);
    i_rst = 1'b0;
    idle(2);
    check("midframe reset no ack", got_q.size(), 0);
    got_q.delete(); got_cyc.delete();
    for (int i = 0; i < 9; i++) send(tbl[0].by[i], 1);
    lc = last_cyc;
    idle(3);
    expect_ev("post reset", ev_ok(1'b0), lc + 1);
    check("post reset acu", acu_now(), ACU_A);
    check("post reset plank id/flags", {o_plank_id, o_plank_flags}, 7'd0);

    // random streams against the frame-level model
    m_acu = ACU_A; m_pid = 3'd0; m_pflags = 4'h0; m_pay_known = 0;
    for (int bt = 0; bt < 15; bt++) begin
      bq.delete(); dq.delete(); exp_q.delete();
      repeat (12) gen_frame();
      model_run();
      foreach (bq[i]) send(bq[i], dq[i]);
      idle(TO + 6);
      check($sformatf("rand b%0d events", bt), got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        check($sformatf("rand b%0d ev%0d", bt, i), got_q[i], exp_q[i]);
      got_q.delete(); got_cyc.delete();
      check($sformatf("rand b%0d acu", bt), acu_now(), m_acu);
      check($sformatf("rand b%0d plank id/flags", bt), {o_plank_id, o_plank_flags}, {m_pid, m_pflags});
      if (m_pay_known)
        for (int a = 0; a < 20; a++) rd_chk(a, (a <= 16) ? m_pay[a] : 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level frame parser between the UART receiver and the ACU/plank control logic of the UART controller. It consumes received bytes, recognises ACU command frames (9 bytes) and plank configuration frames (22 bytes), and checks header, checksum, footer and inter-byte timeout. Valid ACU frames update the attenuator, enable and control registers. Valid plank frames are published through a double-buffered payload RAM, and every frame outcome raises an ACK/NAK strobe for the feedback transmitter.

## Interface

Parameters:
- `TIMEOUT_CYC`, default 17360: maximum idle cycles between bytes inside a frame (2 byte times at 115200 baud, 100 MHz).
- `HDR`, default 8'hAA: header byte.
- `FTR`, default 8'h55: footer byte.

Ports (one clock; reset is synchronous and active-high):
- `i_clk_100`  in  1  system clock, 100 MHz.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_rx_dv`  in  1  one-cycle strobe, `i_rx_byte` valid.
- `i_rx_byte`  in  8  received byte.
- `o_enable`  out  4  ACU enable bits.
- `o_ATT1`, `o_ATT2`, `o_ATT3`, `o_ATT4`  out  6 each  attenuator codes.
- `o_BITE_CNTRL`  out  1  BITE control.
- `o_SUB_ARRAY`  out  1  sub-array select.
- `o_acu_update`  out  1  pulse, ACU registers just updated.
- `o_plank_valid`  out  1  pulse, new plank payload committed.
- `o_plank_id`  out  3  plank index of the committed frame.
- `o_plank_flags`  out  4  type-byte upper nibble of the committed frame.
- `i_plank_rd_addr`  in  5  payload read address, 0..16.
- `o_plank_rd_data`  out  8  payload read data.
- `o_ack_valid`  out  1  pulse, frame outcome.
- `o_ack_byte`  out  8  8'hEE on success, 8'hFF on error.
- `o_frame_err`  out  1  pulse, frame rejected.
- `o_err_code`  out  2  error cause: 0 bad type, 1 checksum, 2 footer, 3 timeout.

## Operation

- **States:** IDLE, TYPE, BODY, CSUM, FOOTER.
- **IDLE:**
  - A byte equal to `HDR` sets the running XOR to `HDR` and moves to TYPE.
  - Any other byte is discarded silently, with no error.
- **TYPE:**
  - Low nibble 4'h1 selects ACU (body length 5). Low nibble 4'h2 selects PLANK (body length 18).
  - The upper nibble is latched as the frame flags.
  - Any other low nibble raises error 0 and returns to IDLE.
- **BODY:** each byte is XORed into the running checksum.
  - ACU: body bytes 0..3 are ATT1..ATT4 (bits [5:0]); byte 4 carries `SUB_ARRAY`=bit1, `BITE`=bit0. All are staged only.
  - PLANK: body bytes 0..16 are written to the inactive payload bank at address 0..16; byte 17 bits [2:0] are the plank id.
- **CSUM:** the received byte must equal the running XOR. On mismatch, raise error 1 and return to IDLE.
- **FOOTER:** the byte must equal `FTR`.
  - Mismatch: raise error 2 and return to IDLE.
  - Match, ACU: the staged fields and flags move to the ACU outputs (`o_enable` = flags); pulse `o_acu_update`.
  - Match, PLANK: toggle the active bank; latch `o_plank_id` and `o_plank_flags`; pulse `o_plank_valid`.
  - Either frame type then returns to IDLE.
- **Outputs on rejection:** every rejected frame leaves all ACU outputs and the active bank unchanged, pulses `o_frame_err` with `o_err_code`, and pulses `o_ack_valid` with `o_ack_byte` = 8'hFF. A good frame pulses `o_ack_valid` with `o_ack_byte` = 8'hEE.
- **Timeout:**
  - A counter clears on each `i_rx_dv` and counts while not in IDLE.
  - On reaching `TIMEOUT_CYC`, raise error 3 and return to IDLE.
  - If `i_rx_dv` arrives in the same cycle as expiry, the byte wins: it is processed and the counter clears.
- **Payload read:** `o_plank_rd_data` = active bank[`i_plank_rd_addr`], registered, 1-cycle latency. Addresses 17..31 return 8'h00.

## Timing

- **Reset values:**
  - All outputs are 0 except `o_ack_byte` = 8'h00.
  - State is IDLE, active bank is 0, timeout counter is 0.
  - Payload RAM contents are not cleared.
- **Reset mid-frame:** the partial frame is abandoned with no error or ACK pulse, and no outputs change other than returning to reset values.
- **Completion latency:** ACU outputs, `o_acu_update`, `o_plank_valid`, `o_ack_valid` and `o_ack_byte` update on the cycle after the footer's `i_rx_dv`. All pulses are exactly 1 cycle wide.
- **Error latency:** error pulses occur on the cycle after the offending byte's `i_rx_dv`, or on the cycle after expiry for a timeout.
- **Back-to-back frames:** a header byte arriving on the cycle right after a footer is accepted, with no dead cycles required.
- **Bank isolation:** readers of the active bank are never disturbed by an in-progress frame. A rejected plank frame leaves the active bank intact.

## Test plan

- **Good ACU frame:** AA F1 33 2A 38 24 03 5D 55 -> `o_enable`=F, ATT1..4=33/2A/38/24, BITE=1, SUB_ARRAY=1, one `o_acu_update`, `o_ack_byte`=EE.
- **Good plank frame:** AA E2, 17×32, 00, 7A, 55 -> `o_plank_valid`, id=0, flags=E, every read address 0..16 returns 32, ack EE. Repeat with id=5 and checksum 7F -> bank toggles back, id=5.
- **Bad checksum:** ACU frame with checksum 5C -> `o_frame_err`, code 1, ack FF, ACU outputs unchanged from the previous frame.
- **Bad footer and bad type:** footer 54 -> code 2. Type byte 0x13 -> code 0 and immediate IDLE. Junk bytes 00 FF ahead of a valid frame are ignored and the frame is accepted.
- **Timeout:** send AA F1 33, then stall `TIMEOUT_CYC` cycles -> code 3. Send a byte exactly on the expiry cycle -> no error. A subsequent full frame is accepted.
- **Reset mid-frame:** assert `i_rst` after 10 plank bytes -> all outputs at reset values, no ack pulse. The next good ACU frame is decoded correctly.
